imem_loader: RTL and testbench

- Write-side counterpart of the CPU instruction fetch path.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory through its write port.
- Holds the CPU (cpu_hold) until a complete program with a valid checksum has been written.
- Sits between the host/bench byte source and instruction_mem. Frame format: SYNC (0xA5), LEN, LEN payload bytes, CSUM.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes a program into instruction memory and releases the CPU once the checksum verifies.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] LOAD_BASE      = '0,
    parameter logic [7:0]        SYNC_BYTE      = 8'hA5,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_w_en,
    output logic [ADDR_W-1:0] imem_w_addr,
    output logic [7:0]        imem_w_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [1:0]        err_code,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {IDLE, SYNC, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        sum_q, sum_d;
    logic [8:0]        words_q, words_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_data_q, w_data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              accept;

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [15:0]       idle_cnt_q, idle_cnt_d;
`else
    logic              unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        in_ready = (state_q == SYNC) || (state_q == LEN) ||
                   (state_q == DATA) || (state_q == CSUM);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        words_d     = words_q;
        w_en_d      = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
`ifdef IMEM_LOADER_TIMEOUT_EN
        idle_cnt_d  = 16'd0;
`endif
        if (start) begin
            // start always (re)opens a frame hunt, abandoning any partial load
            state_d     = SYNC;
            remaining_d = 8'd0;
            sum_d       = 8'd0;
            words_d     = 9'd0;
            hold_d      = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            err_code_d  = 2'b00;
        end else begin
            case (state_q)
                SYNC: if (accept && in_data == SYNC_BYTE) state_d = LEN;
                LEN: if (accept) begin
                    if (in_data == 8'd0) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        remaining_d = in_data;
                        state_d     = DATA;
                    end
                end
                DATA: if (accept) begin
                    w_en_d      = 1'b1;
                    w_data_d    = in_data;
                    w_addr_d    = LOAD_BASE + ADDR_W'(words_q);
                    words_d     = words_q + 9'd1;
                    sum_d       = 8'(sum_q + in_data);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = CSUM;
                end
                CSUM: if (accept) begin
                    if (8'(sum_q + in_data) == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
                default: ;
            endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
            // counter restarts on any accepted byte and on entry to a new state
            if ((state_q == LEN || state_q == DATA || state_q == CSUM) &&
                !accept && state_d == state_q) begin
                if (idle_cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ERR;
                    error_d    = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
            sum_q       <= 8'd0;
            words_q     <= 9'd0;
            w_en_q      <= 1'b0;
            w_addr_q    <= LOAD_BASE;
            w_data_q    <= 8'd0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            words_q     <= words_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign imem_w_en    = w_en_q;
    assign imem_w_addr  = w_addr_q;
    assign imem_w_data  = w_data_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected memory writes are queued by the stimulus and popped by a write monitor.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, imem_w_en, cpu_hold, load_done, load_error;
    logic [7:0] imem_w_addr, imem_w_data;
    logic [1:0] err_code;
    logic [8:0] words_loaded;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(
        .ADDR_W(8), .LOAD_BASE(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_w_en(imem_w_en), .imem_w_addr(imem_w_addr),
        .imem_w_data(imem_w_data), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_w_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got %h@%h expected none", imem_w_data, imem_w_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (imem_w_addr !== e.addr || imem_w_data !== e.data) begin
                    failures++;
                    $display("FAIL write: got %h@%h expected %h@%h",
                             imem_w_data, imem_w_addr, e.data, e.addr);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [7:0] b, input logic [7:0] addr);
        wr_t e;
        e.addr = addr;
        e.data = b;
        exp_q.push_back(e);
        send(b);
        chk("w_latency", {15'd0, imem_w_en}, 16'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_status(input string name, input logic done, input logic err,
                              input logic [1:0] code, input logic hold, input logic [8:0] words);
        chk({name, "_done"}, {15'd0, load_done}, {15'd0, done});
        chk({name, "_error"}, {15'd0, load_error}, {15'd0, err});
        chk({name, "_code"}, {14'd0, err_code}, {14'd0, code});
        chk({name, "_hold"}, {15'd0, cpu_hold}, {15'd0, hold});
        chk({name, "_words"}, {7'd0, words_loaded}, {7'd0, words});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        chk("reset_ready", {15'd0, in_ready}, 16'd0);
        chk("reset_wen", {15'd0, imem_w_en}, 16'd0);
        chk("reset_addr", {8'd0, imem_w_addr}, 16'h0000);
        chk("reset_wdata", {8'd0, imem_w_data}, 16'h0000);
        reset = 1'b0;

        // 1: basic frame, checksum 10+21+32+9D = 0x100
        pulse_start();
        send(8'hA5); send(8'h03);
        send_pay(8'h10, 8'h00); send_pay(8'h21, 8'h01); send_pay(8'h32, 8'h02);
        send(8'h9D);
        chk_status("t1", 1'b1, 1'b0, 2'b00, 1'b0, 9'd3);

        // 2: start from DONE re-holds the CPU; junk before SYNC is discarded
        pulse_start();
        chk_status("t2_start", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        send(8'h00); send(8'h7F); send(8'hA5); send(8'h01);
        send_pay(8'hC4, 8'h00);
        send(8'h3C);
        chk_status("t2", 1'b1, 1'b0, 2'b00, 1'b0, 9'd1);

        // 3: bad checksum, writes stay; then retry succeeds
        pulse_start();
        send(8'hA5); send(8'h02);
        send_pay(8'h11, 8'h00); send_pay(8'h22, 8'h01);
        send(8'h00);
        chk_status("t3", 1'b0, 1'b1, 2'b10, 1'b1, 9'd2);
        chk("t3_ready", {15'd0, in_ready}, 16'd0);
        pulse_start();
        chk_status("t3_retry", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        send(8'hA5); send(8'h01);
        send_pay(8'h55, 8'h00);
        send(8'hAB);
        chk_status("t3_ok", 1'b1, 1'b0, 2'b00, 1'b0, 9'd1);

        // 4: zero length
        pulse_start();
        send(8'hA5); send(8'h00);
        chk_status("t4", 1'b0, 1'b1, 2'b01, 1'b1, 9'd0);

        // 5: gapped in_valid over a 4-byte payload, checksum F6
        pulse_start();
        send(8'hA5); @(negedge clk); send(8'h04); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_pay(8'(i + 1), 8'(i));
            @(negedge clk);
            chk("t5_gap_wen", {15'd0, imem_w_en}, 16'd0);
        end
        send(8'hF6);
        chk_status("t5", 1'b1, 1'b0, 2'b00, 1'b0, 9'd4);

        // abort mid-DATA with start: counters and address restart
        pulse_start();
        send(8'hA5); send(8'h03);
        send_pay(8'h77, 8'h00);
        pulse_start();
        chk_status("abort", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        send(8'hA5); send(8'h01);
        send_pay(8'h88, 8'h00);
        send(8'h78);
        chk_status("abort_ok", 1'b1, 1'b0, 2'b00, 1'b0, 9'd1);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // stall in DATA: error 11 lands 16 cycles after entry
        pulse_start();
        send(8'hA5); send(8'h02);
        repeat (15) @(negedge clk);
        chk("tmo_early", {15'd0, load_error}, 16'd0);
        @(negedge clk);
        chk_status("tmo", 1'b0, 1'b1, 2'b11, 1'b1, 9'd0);
`else
        // without the timeout the loader waits indefinitely
        pulse_start();
        send(8'hA5); send(8'h02);
        repeat (40) @(negedge clk);
        chk_status("no_tmo", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        send_pay(8'h01, 8'h00); send_pay(8'h02, 8'h01);
        send(8'hFD);
        chk_status("no_tmo_ok", 1'b1, 1'b0, 2'b00, 1'b0, 9'd2);
`endif

        // 6: reset mid-DATA, coinciding with a payload byte whose write must be dropped
        pulse_start();
        send(8'hA5); send(8'h05);
        send_pay(8'hAA, 8'h00); send_pay(8'hBB, 8'h01);
        in_valid = 1'b1; in_data = 8'hCC; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk_status("t6", 1'b0, 1'b0, 2'b00, 1'b1, 9'd0);
        chk("t6_wen", {15'd0, imem_w_en}, 16'd0);
        chk("t6_ready", {15'd0, in_ready}, 16'd0);
        chk("t6_addr", {8'd0, imem_w_addr}, 16'h0000);

        repeat (3) @(negedge clk);
        chk("pending_writes", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
